// File: rtl/ftsd_scan_sched_pkg.sv
// ftsd_scan_sched_pkg
// Shared constants and types for the 4-digit 14-segment scan path.
//   FTSD_NUM     : number of multiplexed digits
//   FTSD_CODE_W  : width of one digit code
//   scan_state_e : per-slot scheduler phase (ON = lit window, GAP = anti-ghost blank)
//   DIG0..DIG3   : scan select codes
package ftsd_scan_sched_pkg;

    localparam int FTSD_NUM    = 4;
    localparam int FTSD_CODE_W = 6;

    typedef enum logic {
        SCAN_ON  = 1'b0,
        SCAN_GAP = 1'b1
    } scan_state_e;

    localparam logic [1:0] DIG0 = 2'd0;
    localparam logic [1:0] DIG1 = 2'd1;
    localparam logic [1:0] DIG2 = 2'd2;
    localparam logic [1:0] DIG3 = 2'd3;

endpackage

// File: rtl/ftsd_scan_sched_frame_buf.sv
// ftsd_scan_sched_frame_buf
// Double-buffered frame store. A host write lands in a pending register and
// is copied into the displayed registers only when the parent strobes commit_i,
// so a frame never changes while it is being scanned out.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   wr_valid_i    : host write request
//   wr_data_i     : {d3,d2,d1,d0} digit codes
//   wr_ready_o    : pending register empty (write accepted on valid && ready)
//   commit_i      : frame-boundary strobe from the scheduler
//   disp_o        : committed digit codes, d0 in the low field
module ftsd_scan_sched_frame_buf
    import ftsd_scan_sched_pkg::*;
#(
    parameter logic [FTSD_CODE_W-1:0] RST_CODE = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_valid_i,
    input  logic [FTSD_NUM*FTSD_CODE_W-1:0] wr_data_i,
    output logic                            wr_ready_o,
    input  logic                            commit_i,
    output logic [FTSD_NUM*FTSD_CODE_W-1:0] disp_o
);

    logic                            pending_q;
    logic [FTSD_NUM*FTSD_CODE_W-1:0] pend_data_q;
    logic [FTSD_NUM*FTSD_CODE_W-1:0] disp_q;
    logic                            accept;
    logic                            do_commit;

    // Accept needs an empty buffer and commit needs a full one, so the two
    // can never coincide.
    assign accept    = wr_valid_i && !pending_q;
    assign do_commit = commit_i && pending_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= 1'b0;
            pend_data_q <= '0;
        end else if (accept) begin
            pending_q   <= 1'b1;
            pend_data_q <= wr_data_i;
        end else if (do_commit) begin
            pending_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= {FTSD_NUM{RST_CODE}};
        end else if (do_commit) begin
            disp_q <= pend_data_q;
        end
    end

    // pending_q is a flop, so ready stays free of any input-to-output path.
    assign wr_ready_o = !pending_q;
    assign disp_o     = disp_q;

endmodule

// File: rtl/ftsd_scan_sched.sv
// ftsd_scan_sched
// Scan time base and frame controller for the 4-digit 14-segment display.
// Each digit slot is an ON window of DWELL_CYC cycles followed by a forced
// blank GAP of GAP_CYC cycles; the slot select then advances. Brightness is a
// 16-step PWM applied inside the ON window. Host frames commit at the wrap
// from slot 3 to slot 0, or immediately while the display is disabled.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   en                   : scan enable (0 = dark, scheduler parked at slot 0)
//   bright               : brightness 0..15 (15 = full on)
//   digit_en             : per-digit enable mask
//   wr_valid/wr_data     : host frame write, {d3,d2,d1,d0}
//   wr_ready             : pending buffer empty
//   ftsd_ctl_en          : scan select 0..3
//   ftsd_blank           : all digits off
//   disp0..disp3         : committed digit codes
//   frame_tick           : one-cycle pulse at each frame wrap
module ftsd_scan_sched
    import ftsd_scan_sched_pkg::*;
#(
    parameter int                      DWELL_CYC = 100000,
    parameter int                      GAP_CYC   = 2000,
    parameter logic [FTSD_CODE_W-1:0]  RST_CODE  = 6'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [3:0]             bright,
    input  logic [FTSD_NUM-1:0]    digit_en,
    input  logic                   wr_valid,
    input  logic [23:0]            wr_data,
    output logic                   wr_ready,
    output logic [1:0]             ftsd_ctl_en,
    output logic                   ftsd_blank,
    output logic [FTSD_CODE_W-1:0] disp0,
    output logic [FTSD_CODE_W-1:0] disp1,
    output logic [FTSD_CODE_W-1:0] disp2,
    output logic [FTSD_CODE_W-1:0] disp3,
    output logic                   frame_tick
);

    // One counter serves both phases, so size it for the longer one.
    localparam int CNT_W = $clog2((DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       slot_q, slot_d;
    logic [3:0]       pwm_q, pwm_d;
    logic             blank_q, blank_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic             commit;
    logic [FTSD_NUM*FTSD_CODE_W-1:0] disp_bus;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN_ON;
            cnt_q   <= '0;
            slot_q  <= DIG0;
            pwm_q   <= '0;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            pwm_q   <= pwm_d;
            blank_q <= blank_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        slot_d  = slot_q;
        pwm_d   = pwm_q;
        wrap    = 1'b0;
        if (!en) begin
            // Parked: restart cleanly at slot 0 / ON / count 0 when enabled.
            state_d = SCAN_ON;
            cnt_d   = '0;
            slot_d  = DIG0;
            pwm_d   = '0;
        end else begin
            unique case (state_q)
                SCAN_ON: begin
                    pwm_d = pwm_q + 1'b1;
                    if (cnt_q == DWELL_LAST) begin
                        state_d = SCAN_GAP;
                        cnt_d   = '0;
                    end
                end
                SCAN_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = SCAN_ON;
                        cnt_d   = '0;
                        slot_d  = slot_q + 1'b1;
                        pwm_d   = '0;
                        wrap    = (slot_q == DIG3);
                    end
                end
                default: begin
                    state_d = SCAN_ON;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Blank is decided from the present slot/phase and lands one cycle later;
    // the slot only ever advances out of GAP, so the lag never lights the
    // wrong digit.
    assign blank_d = (state_q == SCAN_GAP) || !en || !digit_en[slot_q] ||
                     (pwm_q > bright);
    assign tick_d  = wrap;
    // While dark nothing is being scanned, so a pending frame can land at once.
    assign commit  = wrap || !en;

    ftsd_scan_sched_frame_buf #(
        .RST_CODE (RST_CODE)
    ) u_frame_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_valid_i (wr_valid),
        .wr_data_i  (wr_data),
        .wr_ready_o (wr_ready),
        .commit_i   (commit),
        .disp_o     (disp_bus)
    );

    assign ftsd_ctl_en = slot_q;
    assign ftsd_blank  = blank_q;
    assign frame_tick  = tick_q;
    assign disp0       = disp_bus[0*FTSD_CODE_W +: FTSD_CODE_W];
    assign disp1       = disp_bus[1*FTSD_CODE_W +: FTSD_CODE_W];
    assign disp2       = disp_bus[2*FTSD_CODE_W +: FTSD_CODE_W];
    assign disp3       = disp_bus[3*FTSD_CODE_W +: FTSD_CODE_W];

endmodule

// File: tb/tb_ftsd_scan_sched.sv
// tb_ftsd_scan_sched
// Self-checking bench: a timeline model (position within a frame computed
// from a cycle index) predicts every output each cycle; literal expectations
// pin the model at the well-known boundaries.
module tb_ftsd_scan_sched;

    localparam int         D     = 32;
    localparam int         G     = 4;
    localparam int         P     = D + G;
    localparam int         FRAME = 4 * P;
    localparam logic [5:0] RSTC  = 6'h2A;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  bright;
    logic [3:0]  digit_en;
    logic        wr_valid;
    logic [23:0] wr_data;
    logic        wr_ready;
    logic [1:0]  ftsd_ctl_en;
    logic        ftsd_blank;
    logic [5:0]  disp0, disp1, disp2, disp3;
    logic        frame_tick;

    ftsd_scan_sched #(
        .DWELL_CYC (D),
        .GAP_CYC   (G),
        .RST_CODE  (RSTC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .bright      (bright),
        .digit_en    (digit_en),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .ftsd_ctl_en (ftsd_ctl_en),
        .ftsd_blank  (ftsd_blank),
        .disp0       (disp0),
        .disp1       (disp1),
        .disp2       (disp2),
        .disp3       (disp3),
        .frame_tick  (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int low_cnt = 0;

    // Model state
    int          m_t;
    bit          m_pend;
    logic [23:0] m_data;
    logic [5:0]  e_disp [4];
    logic [1:0]  e_slot;
    logic        e_blank;
    logic        e_tick;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_t     = 0;
        m_pend  = 0;
        m_data  = '0;
        e_slot  = 2'd0;
        e_blank = 1'b1;
        e_tick  = 1'b0;
        for (int k = 0; k < 4; k++) e_disp[k] = RSTC;
    endtask

    // Advance the model by one clock edge using the inputs presented before it.
    task automatic model_step();
        int pos;
        int slot;
        int pwm;
        bit on;
        bit boundary;
        bit commit;
        pos  = m_t % P;
        slot = (m_t / P) % 4;
        on   = (pos < D);
        pwm  = pos % 16;
        e_blank  = !on || !en || !digit_en[slot] || (pwm > int'(bright));
        boundary = en && (m_t == FRAME - 1);
        e_tick   = boundary;
        commit   = boundary || !en;
        if (commit && m_pend) begin
            for (int k = 0; k < 4; k++) e_disp[k] = m_data[6*k +: 6];
            m_pend = 0;
        end else if (wr_valid && !m_pend) begin
            m_pend = 1;
            m_data = wr_data;
            $display("write accepted: data=%06h cycle=%0d", wr_data, cyc + 1);
        end
        m_t    = en ? (m_t + 1) % FRAME : 0;
        e_slot = 2'((m_t / P) % 4);
    endtask

    task automatic compare_all();
        chk("ctl_en",     32'(ftsd_ctl_en), 32'(e_slot));
        chk("blank",      32'(ftsd_blank),  32'(e_blank));
        chk("frame_tick", 32'(frame_tick),  32'(e_tick));
        chk("wr_ready",   32'(wr_ready),    32'(!m_pend));
        chk("disp0",      32'(disp0),       32'(e_disp[0]));
        chk("disp1",      32'(disp1),       32'(e_disp[1]));
        chk("disp2",      32'(disp2),       32'(e_disp[2]));
        chk("disp3",      32'(disp3),       32'(e_disp[3]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare_all();
        if (ftsd_blank === 1'b0) low_cnt++;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc     = 0;
        low_cnt = 0;
        compare_all();
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        bright   = 4'd15;
        digit_en = 4'hF;
        wr_valid = 1'b0;
        wr_data  = '0;
        model_reset();

        // 1: plain scan, one full frame
        reset_dut();
        chk("rst_blank", 32'(ftsd_blank), 32'd1);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_disp0", 32'(disp0), 32'h2A);
        while (cyc < FRAME) begin
            cycle();
            if (cyc == 35)  chk("slot_c35",  32'(ftsd_ctl_en), 32'd0);
            if (cyc == 36)  chk("slot_c36",  32'(ftsd_ctl_en), 32'd1);
            if (cyc == 72)  chk("slot_c72",  32'(ftsd_ctl_en), 32'd2);
            if (cyc == 108) chk("slot_c108", 32'(ftsd_ctl_en), 32'd3);
            if (cyc == 143) chk("tick_c143", 32'(frame_tick), 32'd0);
            if (cyc == 144) chk("tick_c144", 32'(frame_tick), 32'd1);
        end
        chk("low_full", 32'(low_cnt), 32'd128);

        // 2: write at cycle 10, commits at the frame tick; later writes held off
        reset_dut();
        while (cyc < FRAME) begin
            wr_valid = (cyc == 10) || (cyc >= 20 && cyc < 140);
            wr_data  = (cyc == 10) ? 24'h0C41C5 : 24'hFFFFFF;
            cycle();
            if (cyc == 11)  chk("ready_c11", 32'(wr_ready), 32'd0);
            if (cyc == 143) chk("disp0_c143", 32'(disp0), 32'h2A);
            if (cyc == 144) begin
                chk("disp0_new", 32'(disp0), 32'h05);
                chk("disp1_new", 32'(disp1), 32'h07);
                chk("disp2_new", 32'(disp2), 32'h04);
                chk("disp3_new", 32'(disp3), 32'h03);
                chk("ready_c144", 32'(wr_ready), 32'd1);
            end
        end
        wr_valid = 1'b0;

        // 3: brightness PWM duty
        bright = 4'd3;
        reset_dut();
        repeat (FRAME) cycle();
        chk("low_bright3", 32'(low_cnt), 32'd32);
        bright = 4'd0;
        reset_dut();
        repeat (FRAME) cycle();
        chk("low_bright0", 32'(low_cnt), 32'd8);
        bright = 4'd15;

        // 4: only digit 2 enabled
        digit_en = 4'b0100;
        reset_dut();
        repeat (FRAME) cycle();
        chk("low_dig2", 32'(low_cnt), 32'd32);
        digit_en = 4'hF;

        // 5: write while dark commits two cycles later, then restart
        reset_dut();
        repeat (50) cycle();
        en = 1'b0;
        repeat (2) cycle();
        wr_valid = 1'b1;
        wr_data  = 24'h123456;
        cycle();
        wr_valid = 1'b0;
        cycle();
        chk("dark_disp0", 32'(disp0), 32'h16);
        chk("dark_disp3", 32'(disp3), 32'h04);
        chk("dark_slot",  32'(ftsd_ctl_en), 32'd0);
        chk("dark_blank", 32'(ftsd_blank), 32'd1);
        en = 1'b1;
        cycle();
        chk("restart_blank", 32'(ftsd_blank), 32'd0);
        repeat (FRAME) cycle();

        // 6: async reset mid slot 1 with a frame pending
        reset_dut();
        repeat (50) begin
            wr_valid = (cyc == 5);
            wr_data  = 24'hABCDEF;
            cycle();
        end
        wr_valid = 1'b0;
        chk("pend_before_rst", 32'(wr_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_ready", 32'(wr_ready), 32'd1);
        chk("async_slot",  32'(ftsd_ctl_en), 32'd0);
        chk("async_blank", 32'(ftsd_blank), 32'd1);
        chk("async_disp0", 32'(disp0), 32'h2A);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        compare_all();
        repeat (FRAME + 6) cycle();

        // Random soak
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 249) != 0) ? 1'b1 : (($urandom_range(0, 1) == 0) ? 1'b0 : en);
            if ($urandom_range(0, 49) == 0) bright   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) digit_en = 4'($urandom_range(0, 15));
            wr_valid = ($urandom_range(0, 9) == 0);
            wr_data  = 24'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
